// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the APB DAC scheduler.
package dac_sched_pkg;

  localparam int unsigned DAC_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

  // Encodings match the legacy register values so existing waveforms still decode.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last winner has the highest priority.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 update_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned pos;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    any_o   = |req_i;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr_q) + k) % N;
      if (!found && req_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = IW'(pos);
      end
    end
    ptr_d = IW'((32'(idx_o) + 1) % N);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (update_i && any_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dac_apb_scheduler.sv
// APB master sharing one DAC between N requesters with round-robin arbitration.
// Optional ACCESS timeout enabled by defining DAC_SCHED_TIMEOUT_EN.
module dac_apb_scheduler
  import dac_sched_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [N-1:0]        req,
  input  logic [DAC_DW*N-1:0] wdata,
  output logic [N-1:0]        ack,
  output logic [N-1:0]        err,
  output logic                busy,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DAC_DW-1:0]   PWDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int unsigned IW = $clog2(N);

  if (N < 2 || N > 16 || TIMEOUT == 0) begin : g_bad_cfg
    $error("dac_apb_scheduler: N must be 2..16 and TIMEOUT nonzero");
  end

  state_e              state_q, state_d;
  logic [N-1:0]        win_q, win_d;
  logic [DAC_DW-1:0]   data_q, data_d;
  logic [N-1:0]        ack_q, ack_d;
  logic [N-1:0]        err_q, err_d;
  logic [N-1:0]        arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic                arb_upd;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk_i    (PCLK),
    .rst_ni   (PRESET),
    .req_i    (req),
    .update_i (arb_upd),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

`ifdef DAC_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    data_d  = data_q;
    ack_d   = '0;
    err_d   = '0;
    arb_upd = 1'b0;
`ifdef DAC_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          arb_upd = 1'b1;
          win_d   = arb_grant;
          data_d  = wdata[32'(arb_idx)*DAC_DW +: DAC_DW];
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef DAC_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          ack_d   = win_q;
          err_d   = PSLVERR ? win_q : '0;
          state_d = IDLE;
        end
`ifdef DAC_SCHED_TIMEOUT_EN
        // Expiry is detected on the TIMEOUT-th wait cycle; PREADY above wins a tie.
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ack_d   = win_q;
          err_d   = win_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q <= IDLE;
      win_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef DAC_SCHED_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign PSEL    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = PSEL;
  assign busy    = PSEL;
  assign PWDATA  = data_q;
  assign ack     = ack_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dac_apb_scheduler.sv
// Self-checking bench for dac_apb_scheduler: vector table, hand sequences, random vs. transaction model.
module tb_dac_apb_scheduler;

  localparam int N = 4;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b0;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] wdata = '0;
  logic [N-1:0]    ack, err;
  logic            busy, PSEL, PENABLE, PWRITE;
  logic [31:0]     PWDATA;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  always #5 PCLK = ~PCLK;

  dac_apb_scheduler #(
    .N       (N),
    .TIMEOUT (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req     (req),
    .wdata   (wdata),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  typedef struct {
    logic [N-1:0] req;
    int           waits;
    logic         slverr;
    int           exp_win;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return wdata[i*32 +: 32];
  endfunction

  task automatic randomize_words();
    for (int i = 0; i < N; i++) wdata[i*32 +: 32] = $urandom;
  endtask

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Starts in an IDLE cycle with req set so that the next edge grants; ends in the ack cycle.
  task automatic xfer(input int waits, input logic slverr, input int exp_win,
                      input logic [31:0] exp_data, input logic scramble);
    tick();
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_pwrite", PWRITE, 1);
    chk("setup_busy", busy, 1);
    chk("setup_pwdata", PWDATA, exp_data);
    chk("setup_ack", ack, 0);
    if (scramble) begin
      randomize_words();
      req = N'($urandom_range(0, 15));
    end
    tick();
    chk("access_penable", PENABLE, 1);
    chk("access_psel", PSEL, 1);
    chk("access_pwdata", PWDATA, exp_data);
    for (int i = 0; i <= waits; i++) begin
      PREADY  = (i == waits);
      PSLVERR = (i == waits) ? slverr : 1'($urandom);
      tick();
      if (i < waits) begin
        chk("wait_penable", PENABLE, 1);
        chk("wait_pwdata", PWDATA, exp_data);
        chk("wait_ack", ack, 0);
      end else begin
        chk("done_ack", ack, onehot(exp_win));
        chk("done_err", err, slverr ? onehot(exp_win) : '0);
        chk("done_psel", PSEL, 0);
        chk("done_penable", PENABLE, 0);
        chk("done_pwrite", PWRITE, 0);
        chk("done_busy", busy, 0);
        chk("done_pwdata_kept", PWDATA, exp_data);
      end
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_psel"}, PSEL, 0);
    chk({tag, "_penable"}, PENABLE, 0);
    chk({tag, "_pwrite"}, PWRITE, 0);
    chk({tag, "_pwdata"}, PWDATA, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   win;
    int   n;
    logic [31:0] ed;

    vecs[0] = '{req: 4'b0100, waits: 0, slverr: 1'b0, exp_win: 2};
    vecs[1] = '{req: 4'b1111, waits: 0, slverr: 1'b0, exp_win: 3};
    vecs[2] = '{req: 4'b1111, waits: 0, slverr: 1'b0, exp_win: 0};
    vecs[3] = '{req: 4'b0101, waits: 3, slverr: 1'b0, exp_win: 2};
    vecs[4] = '{req: 4'b0011, waits: 0, slverr: 1'b0, exp_win: 0};
    vecs[5] = '{req: 4'b0011, waits: 0, slverr: 1'b1, exp_win: 1};
    vecs[6] = '{req: 4'b0001, waits: 2, slverr: 1'b0, exp_win: 0};
    vecs[7] = '{req: 4'b1000, waits: 1, slverr: 1'b0, exp_win: 3};

    // Reset
    tick();
    tick();
    check_reset_state("reset");
    PRESET = 1'b1;
    mptr   = 0;

    // Vector table
    foreach (vecs[v]) begin
      randomize_words();
      if (v == 0) wdata[2*32 +: 32] = 32'h8000_0000;
      req = vecs[v].req;
      xfer(vecs[v].waits, vecs[v].slverr, vecs[v].exp_win, word(vecs[v].exp_win), 1'b0);
      req  = '0;
      mptr = (vecs[v].exp_win + 1) % N;
    end

    // All requesters held: strict rotation with an IDLE cycle between transfers
    for (int i = 0; i < N; i++) wdata[i*32 +: 32] = 32'h10 * (i + 1);
    req = 4'b1111;
    xfer(0, 1'b0, 0, 32'h10, 1'b0);
    xfer(0, 1'b0, 1, 32'h20, 1'b0);
    xfer(0, 1'b0, 2, 32'h30, 1'b0);
    xfer(0, 1'b0, 3, 32'h40, 1'b0);
    xfer(0, 1'b0, 0, 32'h10, 1'b0);
    req  = '0;
    mptr = 1;

    // Random transactions against the model, with post-grant noise on req/wdata
    for (int t = 0; t < 40; t++) begin
      randomize_words();
      req = N'($urandom_range(1, 15));
      win = rr_pick(req, mptr);
      ed  = word(win);
      mptr = (win + 1) % N;
      xfer(int'($urandom_range(0, 3)), 1'($urandom), win, ed, 1'b1);
      req = '0;
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("idle_gap_psel", PSEL, 0);
      end
    end

    // Slave never responds
    randomize_words();
    req  = 4'b0100;
    win  = rr_pick(req, mptr);
    ed   = word(win);
    mptr = (win + 1) % N;
    tick();
    chk("to_setup_psel", PSEL, 1);
    req = '0;
    tick();
    n = 0;
`ifdef DAC_SCHED_TIMEOUT_EN
    while (PENABLE === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("timeout_access_cycles", 32'(n), 16);
    chk("timeout_ack", ack, onehot(win));
    chk("timeout_err", err, onehot(win));
    chk("timeout_psel", PSEL, 0);
`else
    for (int c = 0; c < 100; c++) begin
      if (PENABLE === 1'b1 && PSEL === 1'b1 && ack === '0) n++;
      tick();
    end
    chk("no_timeout_access_cycles", 32'(n), 100);
    chk("no_timeout_still_access", PENABLE, 1);
    chk("no_timeout_pwdata", PWDATA, ed);
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    chk("late_ready_ack", ack, onehot(win));
    chk("late_ready_err", err, 0);
`endif

    // Reset in the middle of ACCESS restores the pointer to requester 0
    PRESET = 1'b0;
    tick();
    PRESET = 1'b1;
    randomize_words();
    req = 4'b0100;
    xfer(0, 1'b0, 2, word(2), 1'b0);
    req = 4'b0010;
    tick();
    tick();
    chk("pre_reset_access", PENABLE, 1);
    PRESET = 1'b0;
    req    = 4'b1001;
    tick();
    check_reset_state("midreset");
    PRESET = 1'b1;
    xfer(0, 1'b0, 0, word(0), 1'b0);
    xfer(0, 1'b0, 3, word(3), 1'b0);
    req = '0;
    tick();
    chk("final_idle_ack", ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
